pwm_compare_scheduler: RTL

- Time-multiplexes one shared 8-bit equality comparator across N_CH PWM channels of the motion-controller PWM stage.
- Owns the period counter, per-channel duty registers (shadow and active), and the channel scan sequence.
- Drives the comparator's A/B inputs and consumes its equality result to set and clear each channel's PWM output.
- The comparator is instantiated outside this block and connected through the cmp_* ports.

---
 rtl/pwm_compare_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_compare_scheduler.sv
// pwm_compare_scheduler
// Shares one external 8-bit equality comparator across N_CH PWM channels.
// A period counter runs 0..PERIOD_MAX; each count value gets a frame of
// N_CH scan slots (one per channel) followed by one ADVANCE slot.
// Duty values are written into shadow registers and copied into the active
// set only on scheduler entry and at the period wrap, so a period never
// sees a duty change part-way through.
// Optional feature macro: PWM_SYNC_PULSE_EN adds the period_sync output.
//
// Handshake: duty_wr is a single-cycle strobe that is always accepted;
// duty_ack is asserted for exactly one cycle on the clock after duty_wr,
// including for discarded writes to channel indices >= N_CH.
module pwm_compare_scheduler #(
  parameter int          N_CH       = 4,
  parameter int          CH_W       = 2,
  parameter logic [7:0]  PERIOD_MAX = 8'd255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            duty_wr,
  input  logic [CH_W-1:0] duty_ch,
  input  logic [7:0]      duty_data,
  output logic            duty_ack,
  output logic [7:0]      cmp_a,
  output logic [7:0]      cmp_b,
  input  logic            cmp_eq,
`ifdef PWM_SYNC_PULSE_EN
  output logic            period_sync,
`endif
  output logic [N_CH-1:0] pwm_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    ADVANCE = 2'd2
  } state_e;

  // state_q is the FSM state; observable hierarchically for checkers.
  state_e            state_q;
  logic [7:0]        count_q;
  logic [CH_W-1:0]   index_q;
  logic [N_CH-1:0]   pwm_q;
  logic              ack_q;
  logic [7:0]        shadow_q [N_CH];
  logic [7:0]        active_q [N_CH];
  logic [7:0]        shadow_d [N_CH];
  logic [7:0]        scan_duty;
`ifdef PWM_SYNC_PULSE_EN
  logic              period_sync_q;
`endif

  // Shadow contents after this cycle's write; the copy into active uses
  // this so a write landing on the copy cycle is included in the copy.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (duty_wr && (duty_ch == CH_W'(i))) begin
        shadow_d[i] = duty_data;
      end
    end
  end

  // Active duty of the channel currently being scanned.
  always_comb begin
    scan_duty = 8'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (index_q == CH_W'(i)) begin
        scan_duty = active_q[i];
      end
    end
  end

  // Comparator operands are only meaningful in SCAN; parked at zero otherwise.
  assign cmp_a    = (state_q == SCAN) ? count_q   : 8'd0;
  assign cmp_b    = (state_q == SCAN) ? scan_duty : 8'd0;
  assign duty_ack = ack_q;
  assign pwm_out  = pwm_q;
`ifdef PWM_SYNC_PULSE_EN
  assign period_sync = period_sync_q;
`endif

  // Scheduler FSM, period counter, duty registers and PWM outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      index_q <= '0;
      pwm_q   <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= 8'd0;
        active_q[i] <= 8'd0;
      end
`ifdef PWM_SYNC_PULSE_EN
      period_sync_q <= 1'b0;
`endif
    end else begin
      ack_q <= duty_wr;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
`ifdef PWM_SYNC_PULSE_EN
      period_sync_q <= 1'b0;
`endif
      if (!enable) begin
        // Stop from any state: outputs drop on this same edge.
        state_q <= IDLE;
        count_q <= 8'd0;
        index_q <= '0;
        pwm_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            for (int i = 0; i < N_CH; i++) begin
              active_q[i] <= shadow_d[i];
            end
            count_q <= 8'd0;
            index_q <= '0;
            state_q <= SCAN;
`ifdef PWM_SYNC_PULSE_EN
            period_sync_q <= 1'b1;
`endif
          end
          SCAN: begin
            // Count 0 starts the period high unless duty is 0; a later
            // match latches the channel low for the rest of the period.
            for (int i = 0; i < N_CH; i++) begin
              if (index_q == CH_W'(i)) begin
                if (count_q == 8'd0) begin
                  pwm_q[i] <= ~cmp_eq;
                end else begin
                  pwm_q[i] <= pwm_q[i] & ~cmp_eq;
                end
              end
            end
            if (index_q == CH_W'(N_CH - 1)) begin
              state_q <= ADVANCE;
            end else begin
              index_q <= index_q + 1'b1;
            end
          end
          ADVANCE: begin
            if (count_q == PERIOD_MAX) begin
              count_q <= 8'd0;
              for (int i = 0; i < N_CH; i++) begin
                active_q[i] <= shadow_d[i];
              end
`ifdef PWM_SYNC_PULSE_EN
              period_sync_q <= 1'b1;
`endif
            end else begin
              count_q <= count_q + 8'd1;
            end
            index_q <= '0;
            state_q <= SCAN;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
